// File: rtl/skin_box_tracker_if.sv
// Binary pixel stream from the threshold comparator, with its aligned syncs.
// Latency: none, this is a plain signal bundle.
// Backpressure: none; the stream is free-running and sinks must keep up.
interface skin_box_tracker_if #(
    parameter int IMG_WIDTH_DATA = 24
) ();
    logic [IMG_WIDTH_DATA-1:0] binary;
    logic                      hsync;
    logic                      vsync;
    logic                      de;

    modport master (output binary, output hsync, output vsync, output de);
    modport slave  (input  binary, input  hsync, input  vsync, input  de);
endinterface

// File: rtl/skin_box_tracker.sv
// Tracks the per-frame skin bounding box and pixel count; owns the Cb/Cr thresholds (frame-boundary shadowed).
// Latency: box outputs and box_valid update on the clock edge that sees vsync rise.
// Backpressure: none; the pixel stream is consumed at one pixel per clock.
module skin_box_tracker #(
    parameter int IMG_WIDTH_DATA = 24,
    parameter int COORD_W        = 12,
    parameter int CNT_W          = 24,
    parameter int CB_LOW_INIT    = 123,
    parameter int CB_HIGH_INIT   = 165,
    parameter int CR_LOW_INIT    = 110,
    parameter int CR_HIGH_INIT   = 132
) (
    input  logic               pixelclk,
    input  logic               reset_n,
    skin_box_tracker_if.slave  pix,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [7:0]         cfg_wdata,
    output logic [7:0]         cb_low,
    output logic [7:0]         cb_high,
    output logic [7:0]         cr_low,
    output logic [7:0]         cr_high,
    output logic [COORD_W-1:0] box_x_min,
    output logic [COORD_W-1:0] box_x_max,
    output logic [COORD_W-1:0] box_y_min,
    output logic [COORD_W-1:0] box_y_max,
    output logic [CNT_W-1:0]   skin_count,
    output logic               box_found,
    output logic               box_valid
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state_q, state_d;

    logic v_d, de_d;
    logic vs_rise, de_fall;
    logic frame_close, acc_en, skin_pix;

    logic [7:0] sh_cb_low, sh_cb_high, sh_cr_low, sh_cr_high;

    logic [COORD_W-1:0] x_cnt, y_cnt;
    logic [COORD_W-1:0] acc_x_min, acc_x_max, acc_y_min, acc_y_max;
    logic [CNT_W-1:0]   acc_cnt;
    logic               acc_found;

    // hsync only travels with the stream; coordinates come from de and vsync alone.
    logic unused_hsync;
    assign unused_hsync = pix.hsync;

    assign vs_rise  = pix.vsync & ~v_d;
    assign de_fall  = ~pix.de & de_d;
    assign skin_pix = pix.de && (pix.binary == '0);

    // Delayed syncs for edge detection.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            v_d  <= 1'b0;
            de_d <= 1'b0;
        end else begin
            v_d  <= pix.vsync;
            de_d <= pix.de;
        end
    end

    // FSM state register.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state; the first vsync edge after reset only arms accumulation.
    always_comb begin
        state_d     = state_q;
        frame_close = 1'b0;
        acc_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (vs_rise) state_d = ACTIVE;
            end
            ACTIVE: begin
                frame_close = vs_rise;
                acc_en      = ~vs_rise;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shadow threshold writes, accepted in any state.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            sh_cb_low  <= 8'(CB_LOW_INIT);
            sh_cb_high <= 8'(CB_HIGH_INIT);
            sh_cr_low  <= 8'(CR_LOW_INIT);
            sh_cr_high <= 8'(CR_HIGH_INIT);
        end else if (cfg_we) begin
            case (cfg_addr)
                2'd0:    sh_cb_low  <= cfg_wdata;
                2'd1:    sh_cb_high <= cfg_wdata;
                2'd2:    sh_cr_low  <= cfg_wdata;
                default: sh_cr_high <= cfg_wdata;
            endcase
        end
    end

    // Active thresholds move only on a frame edge; a write on that same cycle bypasses the shadow.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            cb_low  <= 8'(CB_LOW_INIT);
            cb_high <= 8'(CB_HIGH_INIT);
            cr_low  <= 8'(CR_LOW_INIT);
            cr_high <= 8'(CR_HIGH_INIT);
        end else if (vs_rise) begin
            cb_low  <= (cfg_we && cfg_addr == 2'd0) ? cfg_wdata : sh_cb_low;
            cb_high <= (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : sh_cb_high;
            cr_low  <= (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : sh_cr_low;
            cr_high <= (cfg_we && cfg_addr == 2'd3) ? cfg_wdata : sh_cr_high;
        end
    end

    // Saturating pixel coordinates; a frame edge beats a line end for y.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            if (de_fall)
                x_cnt <= '0;
            else if (pix.de && x_cnt != '1)
                x_cnt <= x_cnt + 1'b1;

            if (vs_rise)
                y_cnt <= '0;
            else if (de_fall && y_cnt != '1)
                y_cnt <= y_cnt + 1'b1;
        end
    end

    // Bounding-box and count accumulation; cleared as the frame closes.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            acc_x_min <= '0;
            acc_x_max <= '0;
            acc_y_min <= '0;
            acc_y_max <= '0;
            acc_cnt   <= '0;
            acc_found <= 1'b0;
        end else if (frame_close) begin
            acc_x_min <= '0;
            acc_x_max <= '0;
            acc_y_min <= '0;
            acc_y_max <= '0;
            acc_cnt   <= '0;
            acc_found <= 1'b0;
        end else if (acc_en && skin_pix) begin
            if (!acc_found) begin
                acc_x_min <= x_cnt;
                acc_x_max <= x_cnt;
                acc_y_min <= y_cnt;
                acc_y_max <= y_cnt;
                acc_cnt   <= CNT_W'(1);
                acc_found <= 1'b1;
            end else begin
                if (x_cnt < acc_x_min) acc_x_min <= x_cnt;
                if (x_cnt > acc_x_max) acc_x_max <= x_cnt;
                if (y_cnt < acc_y_min) acc_y_min <= y_cnt;
                if (y_cnt > acc_y_max) acc_y_max <= y_cnt;
                if (acc_cnt != '1) acc_cnt <= acc_cnt + 1'b1;
            end
        end
    end

    // Publish the closed frame; outputs hold until the next close.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            box_x_min  <= '0;
            box_x_max  <= '0;
            box_y_min  <= '0;
            box_y_max  <= '0;
            skin_count <= '0;
            box_found  <= 1'b0;
            box_valid  <= 1'b0;
        end else begin
            box_valid <= frame_close;
            if (frame_close) begin
                box_found  <= acc_found;
                box_x_min  <= acc_found ? acc_x_min : '0;
                box_x_max  <= acc_found ? acc_x_max : '0;
                box_y_min  <= acc_found ? acc_y_min : '0;
                box_y_max  <= acc_found ? acc_y_max : '0;
                skin_count <= acc_found ? acc_cnt   : '0;
            end
        end
    end

endmodule

// File: tb/tb_skin_box_tracker.sv
// Directed bench for skin_box_tracker with hand-computed expectations.
// Latency: checks sample #1 after the rising edge that registers each event.
// Backpressure: none; stimulus drives the stream one pixel per clock.
module tb_skin_box_tracker;

    logic        pixelclk = 1'b0;
    logic        reset_n;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic [7:0]  cb_low, cb_high, cr_low, cr_high;
    logic [11:0] box_x_min, box_x_max, box_y_min, box_y_max;
    logic [23:0] skin_count;
    logic        box_found, box_valid;

    int tests  = 0;
    int failed = 0;

    skin_box_tracker_if #(.IMG_WIDTH_DATA(24)) pix_if ();

    skin_box_tracker dut (
        .pixelclk   (pixelclk),
        .reset_n    (reset_n),
        .pix        (pix_if.slave),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cb_low     (cb_low),
        .cb_high    (cb_high),
        .cr_low     (cr_low),
        .cr_high    (cr_high),
        .box_x_min  (box_x_min),
        .box_x_max  (box_x_max),
        .box_y_min  (box_y_min),
        .box_y_max  (box_y_max),
        .skin_count (skin_count),
        .box_found  (box_found),
        .box_valid  (box_valid)
    );

    always #5 pixelclk = ~pixelclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge pixelclk);
        #1;
    endtask

    task automatic set_pix(input logic de, input logic skin);
        pix_if.de     = de;
        pix_if.hsync  = ~de;
        pix_if.binary = (de && skin) ? 24'h000000 : 24'hFFFFFF;
    endtask

    // One line of w pixels (mask bit i = skin at x=i), then two blank cycles.
    task automatic send_line(input int w, input logic [7:0] mask);
        for (int i = 0; i < w; i++) begin
            set_pix(1'b1, mask[i]);
            tick();
        end
        set_pix(1'b0, 1'b0);
        tick();
        tick();
    endtask

    task automatic vs_high;
        set_pix(1'b0, 1'b0);
        pix_if.vsync = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic vs_low;
        pix_if.vsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        cfg_we        = 1'b0;
        cfg_addr      = 2'd0;
        cfg_wdata     = 8'd0;
        pix_if.vsync  = 1'b0;
        set_pix(1'b0, 1'b0);
        tick();
        tick();

        // Reset values.
        check("rst_cb_low",  cb_low,  123);
        check("rst_cb_high", cb_high, 165);
        check("rst_cr_low",  cr_low,  110);
        check("rst_cr_high", cr_high, 132);
        check("rst_valid",   box_valid, 0);
        check("rst_found",   box_found, 0);
        check("rst_count",   skin_count, 0);
        check("rst_xmax",    box_x_max, 0);
        reset_n = 1'b1;
        tick();

        // First vsync edge only arms the tracker.
        vs_high();
        check("idle_edge_valid", box_valid, 0);
        vs_low();

        // 8x4 all non-skin frame.
        for (int l = 0; l < 4; l++) send_line(8, 8'h00);
        vs_high();
        check("empty_valid", box_valid, 1);
        check("empty_found", box_found, 0);
        check("empty_count", skin_count, 0);
        check("empty_xmin",  box_x_min, 0);
        check("empty_xmax",  box_x_max, 0);
        check("empty_ymin",  box_y_min, 0);
        check("empty_ymax",  box_y_max, 0);
        vs_low();
        check("empty_valid_drop", box_valid, 0);

        // 8x4 frame, skin at (2,1),(5,1),(3,3); CB_LOW written mid-frame.
        send_line(8, 8'h00);
        send_line(8, 8'h24);
        cfg_write(2'd0, 8'd100);
        check("cb_low_held_mid", cb_low, 123);
        send_line(8, 8'h00);
        send_line(8, 8'h08);
        check("cb_low_held_end", cb_low, 123);
        cfg_we    = 1'b1;
        cfg_addr  = 2'd3;
        cfg_wdata = 8'd140;
        vs_high();
        check("box_valid", box_valid, 1);
        check("box_found", box_found, 1);
        check("box_xmin",  box_x_min, 2);
        check("box_xmax",  box_x_max, 5);
        check("box_ymin",  box_y_min, 1);
        check("box_ymax",  box_y_max, 3);
        check("box_count", skin_count, 3);
        check("cb_low_loaded",   cb_low, 100);
        check("cr_high_bypass",  cr_high, 140);
        check("cb_high_kept",    cb_high, 165);
        vs_low();
        check("box_valid_drop", box_valid, 0);
        check("box_xmin_hold",  box_x_min, 2);

        // 5000-pixel line, only the last pixel skin: x saturates.
        for (int i = 0; i < 5000; i++) begin
            set_pix(1'b1, i == 4999);
            tick();
        end
        set_pix(1'b0, 1'b0);
        tick();
        tick();
        vs_high();
        check("sat_valid", box_valid, 1);
        check("sat_xmin",  box_x_min, 4095);
        check("sat_xmax",  box_x_max, 4095);
        check("sat_ymax",  box_y_max, 0);
        check("sat_count", skin_count, 1);
        vs_low();

        // Mid-frame reset after three skin pixels and a pending shadow write.
        cfg_write(2'd1, 8'd50);
        send_line(8, 8'h07);
        reset_n = 1'b0;
        tick();
        check("mrst_valid",   box_valid, 0);
        check("mrst_count",   skin_count, 0);
        check("mrst_cb_low",  cb_low, 123);
        check("mrst_cr_high", cr_high, 132);
        tick();
        reset_n = 1'b1;
        tick();
        vs_high();
        check("mrst_idle_valid", box_valid, 0);
        check("mrst_cb_high",    cb_high, 165);
        vs_low();
        send_line(8, 8'h01);
        send_line(8, 8'h00);
        send_line(8, 8'h80);
        send_line(8, 8'h00);
        vs_high();
        check("post_valid", box_valid, 1);
        check("post_count", skin_count, 2);
        check("post_xmin",  box_x_min, 0);
        check("post_xmax",  box_x_max, 7);
        check("post_ymin",  box_y_min, 0);
        check("post_ymax",  box_y_max, 2);
        vs_low();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/skin_box_tracker.md
Name: skin_box_tracker

Overview:
- Frame-level controller for the YCbCr skin-location datapath.
- Owns the Cb/Cr threshold registers that feed the threshold comparator, and holds them in shadow copies so new values apply only at frame boundaries.
- Consumes the comparator's binary output stream (the one with aligned hsync/vsync/de) and tracks pixel coordinates.
- Per frame, reports the bounding box and count of skin pixels, for overlay and face-location logic downstream.

Parameters:
- IMG_WIDTH_DATA, 24, width of the binary pixel bus.
- COORD_W, 12, width of the x/y coordinate counters and box outputs.
- CNT_W, 24, width of the skin-pixel counter.
- CB_LOW_INIT, 123, reset value of Cb lower bound (shadow and active).
- CB_HIGH_INIT, 165, reset value of Cb upper bound.
- CR_LOW_INIT, 110, reset value of Cr lower bound.
- CR_HIGH_INIT, 132, reset value of Cr upper bound.

Ports:
- pixelclk  in  1  pixel clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_binary  in  IMG_WIDTH_DATA  binary pixel; all-zero = skin, any other value = non-skin.
- i_hsync  in  1  line sync, aligned with i_binary (pass-through only).
- i_vsync  in  1  frame sync, active high.
- i_de  in  1  data enable; i_binary valid when high.
- cfg_we  in  1  shadow-register write strobe.
- cfg_addr  in  2  0=CB_LOW, 1=CB_HIGH, 2=CR_LOW, 3=CR_HIGH.
- cfg_wdata  in  8  write data.
- cb_low, cb_high, cr_low, cr_high  out  8 each  active thresholds to the comparator.
- box_x_min, box_x_max, box_y_min, box_y_max  out  COORD_W each  last completed frame's box.
- skin_count  out  CNT_W  skin pixels in last completed frame.
- box_found  out  1  last completed frame contained at least one skin pixel.
- box_valid  out  1  one-cycle pulse when the box outputs update.

Behaviour:
- Reset:
  - Shadow and active thresholds take their *_INIT values.
  - All box outputs, skin_count, box_found, box_valid and internal counters go to 0.
  - FSM goes to IDLE.
- Edge detect:
  - v_d is i_vsync registered. vs_rise = i_vsync & ~v_d.
  - de_d is i_de registered. de_fall = ~i_de & de_d.
- FSM states:
  - IDLE: wait for vs_rise, then go to ACTIVE. No box_valid on this first edge. Thresholds do load.
  - ACTIVE: accumulate. Each vs_rise closes the frame and stays in ACTIVE.
- Coordinates:
  - x counts i_de-high cycles within a line, starting at 0. x resets to 0 on de_fall.
  - y increments on de_fall and resets to 0 on vs_rise.
  - Both saturate at 2^COORD_W-1; no wrap.
- Accumulation (ACTIVE, i_de=1, i_binary==0):
  - First skin pixel of the frame loads min=max=current x/y and sets an internal found flag.
  - Later skin pixels update min/max per axis and increment the count, saturating at 2^CNT_W-1.
  - The pixel present on the vs_rise cycle is ignored.
- Frame close (vs_rise in ACTIVE), applied on that clock edge:
  - Copy accumulators and found flag to the outputs.
  - If found=0, all box coordinates and skin_count output as 0.
  - box_valid is high for exactly the next cycle.
  - Accumulators and found clear on the same edge.
- Thresholds:
  - cfg_we writes the addressed shadow register every cycle, regardless of FSM state.
  - On every vs_rise (IDLE or ACTIVE), active registers load from shadow.
  - If cfg_we coincides with vs_rise, the written field loads cfg_wdata directly (write wins); other fields load their shadow.
  - The comparator never sees a threshold change mid-frame.
- Simultaneous events:
  - de_fall with vs_rise: the y reset wins.
- i_hsync is unused except for documentation alignment; the coordinate logic depends only on i_de and i_vsync.
- Reset mid-frame:
  - Abandons the frame with no box_valid.
  - Active thresholds return to *_INIT, discarding pending shadow writes.
- Output latency: box outputs are stable from the box_valid cycle until the next frame close.

Test Plan:
- Reset, then 8x4 frame, all pixels non-skin, two vsync pulses -> after 2nd vs_rise: box_valid one cycle, box_found=0, all box fields and skin_count=0.
- 8x4 frame with skin pixels at (2,1),(5,1),(3,3) -> x_min=2, x_max=5, y_min=1, y_max=3, skin_count=3, box_found=1.
- Write CB_LOW=100 mid-frame -> cb_low stays 123 until next vs_rise, then 100 the following cycle.
- cfg_we (addr 3, data 140) in the same cycle as vs_rise -> cr_high=140 after that edge.
- Line of 5000 de cycles with skin at end -> x_max saturates at 4095, no wrap.
- reset_n low mid-frame after 3 skin pixels -> no box_valid. Next full frame reports only its own pixels. Thresholds at INIT.
